mul_share_arb: RTL and testbench

MUL_SHARE_ARB -- requirements
Module: mul_share_arb

---
 rtl/mul_share_arb.sv | 131 +++++++++++++
 tb/tb_mul_share_arb.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/mul_share_arb.sv
// Two-port arbiter sharing one 8x8 unsigned array multiplier behind a one-entry output register.
// Optional per-port completion counters are enabled with `define MUL_SHARE_PERF_EN.

module mul8x8_array (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p
);
    localparam int unsigned OP_W = 8;

    // Shift-and-add over the partial-product rows
    always_comb begin
        p = '0;
        for (int i = 0; i < OP_W; i++) begin
            if (b[i]) begin
                p = p + (16'(a) << i);
            end
        end
    end
endmodule

module mul_share_arb #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in0_valid,
    input  logic [7:0]       in0_a,
    input  logic [7:0]       in0_b,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [7:0]       in1_a,
    input  logic [7:0]       in1_b,
    output logic             in1_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_r,
    output logic             out_id
`ifdef MUL_SHARE_PERF_EN
    ,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
`endif
);
    localparam int unsigned OP_W  = 8;
    localparam int unsigned RES_W = 2 * OP_W;

    if (CNT_W < 1) begin : g_cnt_w_check
        $error("CNT_W must be at least 1");
    end

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic               last_grant;
    logic               gnt;
    logic               any_req;
    logic               can_accept;
    logic               accept;
    logic [OP_W-1:0]    op_a;
    logic [OP_W-1:0]    op_b;
    logic [RES_W-1:0]   prod;

    mul8x8_array u_mul (
        .a (op_a),
        .b (op_b),
        .p (prod)
    );

    // Grant, handshake and next-state; a tie goes to the port that did not win last
    always_comb begin
        any_req    = in0_valid | in1_valid;
        gnt        = 1'b0;
        can_accept = (state_q == EMPTY) || out_ready;
        accept     = 1'b0;
        state_d    = state_q;

        if (in0_valid && in1_valid) begin
            gnt = ~last_grant;
        end else if (in1_valid) begin
            gnt = 1'b1;
        end

        accept    = any_req && can_accept && !rst;
        in0_ready = accept && !gnt;
        in1_ready = accept && gnt;
        op_a      = gnt ? in1_a : in0_a;
        op_b      = gnt ? in1_b : in0_b;

        case (state_q)
            EMPTY:   if (accept) state_d = FULL;
            FULL:    if (out_ready && !accept) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            out_r      <= '0;
            out_id     <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            state_q <= state_d;
            if (accept) begin
                out_r      <= prod;
                out_id     <= gnt;
                last_grant <= gnt;
            end
        end
    end

    assign out_valid = (state_q == FULL);

`ifdef MUL_SHARE_PERF_EN
    // Saturating completion counters, bumped on each output handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else if (out_valid && out_ready) begin
            if (!out_id && (cnt0 != {CNT_W{1'b1}})) cnt0 <= cnt0 + CNT_W'(1);
            if (out_id && (cnt1 != {CNT_W{1'b1}}))  cnt1 <= cnt1 + CNT_W'(1);
        end
    end
`endif
endmodule

// File: tb/tb_mul_share_arb.sv
// Directed self-checking bench for mul_share_arb; counter checks build with MUL_SHARE_PERF_EN.

module tb_mul_share_arb;
`ifdef MUL_SHARE_PERF_EN
    localparam int unsigned CNT_W = 4;
`else
    localparam int unsigned CNT_W = 16;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             in0_valid, in1_valid;
    logic [7:0]       in0_a, in0_b, in1_a, in1_b;
    logic             in0_ready, in1_ready;
    logic             out_valid, out_ready;
    logic [15:0]      out_r;
    logic             out_id;
`ifdef MUL_SHARE_PERF_EN
    logic [CNT_W-1:0] cnt0, cnt1;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mul_share_arb #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in0_valid (in0_valid),
        .in0_a     (in0_a),
        .in0_b     (in0_b),
        .in0_ready (in0_ready),
        .in1_valid (in1_valid),
        .in1_a     (in1_a),
        .in1_b     (in1_b),
        .in1_ready (in1_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .out_id    (out_id)
`ifdef MUL_SHARE_PERF_EN
        ,
        .cnt0      (cnt0),
        .cnt1      (cnt1)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [15:0] r, input logic id);
        check({tag, ".valid"}, 32'(out_valid), 32'(v));
        check({tag, ".r"},     32'(out_r),     32'(r));
        check({tag, ".id"},    32'(out_id),    32'(id));
    endtask

    task automatic check_rdy(input string tag, input logic r0, input logic r1);
        #1;
        check({tag, ".rdy0"}, 32'(in0_ready), 32'(r0));
        check({tag, ".rdy1"}, 32'(in1_ready), 32'(r1));
    endtask

    initial begin
        rst = 1'b1; out_ready = 1'b0;
        in0_valid = 1'b1; in1_valid = 1'b1;
        in0_a = 8'd0; in0_b = 8'd0; in1_a = 8'd0; in1_b = 8'd0;
        step(); step();
        check_out("reset", 1'b0, 16'h0000, 1'b0);
        check_rdy("reset", 1'b0, 1'b0);

        // Port 0 only: 13*11
        rst = 1'b0; in1_valid = 1'b0; out_ready = 1'b1;
        in0_a = 8'd13; in0_b = 8'd11;
        check_rdy("p0_req", 1'b1, 1'b0);
        step();
        in0_valid = 1'b0;
        check_out("p0_13x11", 1'b1, 16'h008F, 1'b0);
        check_rdy("p0_idle", 1'b0, 1'b0);
        step();
        check_out("drain0", 1'b0, 16'h008F, 1'b0);

        // Port 1 only: 255*255, full 16-bit product
        in1_valid = 1'b1; in1_a = 8'd255; in1_b = 8'd255;
        check_rdy("p1_req", 1'b0, 1'b1);
        step();
        in1_valid = 1'b0;
        check_out("p1_255x255", 1'b1, 16'hFE01, 1'b1);
        step();
        check_out("drain1", 1'b0, 16'hFE01, 1'b1);

        // Sustained dual requests from reset alternate 0,1,0,1 at one per cycle
        rst = 1'b1; step(); rst = 1'b0;
        in0_valid = 1'b1; in0_a = 8'd2; in0_b = 8'd3;
        in1_valid = 1'b1; in1_a = 8'd4; in1_b = 8'd5;
        check_rdy("tie_first", 1'b1, 1'b0);
        for (int k = 0; k < 6; k++) begin
            step();
            check_out($sformatf("alt%0d", k), 1'b1, (k % 2 == 0) ? 16'd6 : 16'd20, 1'(k % 2));
        end

        // Backpressure: hold id1 result, no grants, pointer untouched
        out_ready = 1'b0;
        check_rdy("bp_now", 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step();
            check_out($sformatf("bp%0d", k), 1'b1, 16'd20, 1'b1);
            check_rdy($sformatf("bp%0d", k), 1'b0, 1'b0);
        end
        out_ready = 1'b1;
        check_rdy("bp_release", 1'b1, 1'b0);
        step();
        check_out("bp_after", 1'b1, 16'd6, 1'b0);

        // Reset while FULL discards the result and restores port-0 tie priority
        out_ready = 1'b0; in0_valid = 1'b0; in1_valid = 1'b0;
        step();
        check_out("pre_rst", 1'b1, 16'd6, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_out("mid_rst", 1'b0, 16'h0000, 1'b0);
        in0_valid = 1'b1; in1_valid = 1'b1; out_ready = 1'b1;
        check_rdy("post_rst_tie", 1'b1, 1'b0);
        step();
        check_out("post_rst", 1'b1, 16'd6, 1'b0);
        in0_valid = 1'b0; in1_valid = 1'b0;
        step();
        check_out("post_rst_drain", 1'b0, 16'd6, 1'b0);

`ifdef MUL_SHARE_PERF_EN
        // 17 port-0 completions saturate a 4-bit counter
        rst = 1'b1; step(); rst = 1'b0;
        check("cnt0_reset", 32'(cnt0), 32'h0);
        in0_valid = 1'b1; in0_a = 8'd7; in0_b = 8'd9; out_ready = 1'b1;
        for (int k = 0; k < 17; k++) step();
        in0_valid = 1'b0;
        step();
        check("cnt0_sat", 32'(cnt0), 32'hF);
        check("cnt1_zero", 32'(cnt1), 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
